// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//   Shared types and constants for the SPI controller slice.
//   - spi_ctrl_state_t : controller FSM state encoding
//   - SPI_MIN_CLK_DIV  : smallest legal sck half-period in clk cycles; two of
//                        those cycles are taken by the miso synchronizer
// -----------------------------------------------------------------------------
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      NEXT,
      HOLD,
      GAP
   } spi_ctrl_state_t;

   localparam int unsigned SPI_MIN_CLK_DIV = 4;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for asynchronous inputs. Resets to zero.
//   Ports:
//     clk    in   sampling clock, rising edge
//     rst_n  in   asynchronous active-low reset
//     i_d    in   WIDTH  asynchronous input
//     o_q    out  WIDTH  input re-timed into the clk domain (2-cycle latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/spi_controller.sv
// -----------------------------------------------------------------------------
// spi_controller
//   SPI bus master, mode 0 (CPOL=0, CPHA=0), MSB first. Bytes arrive on a
//   valid/ready stream; tx_last closes the frame. Received bytes leave as a
//   one-cycle rx_valid strobe with rx_data held until the next strobe.
//   Parameters:
//     CLK_DIV  sck half-period in clk cycles (>= SPI_MIN_CLK_DIV)
//     CS_IDLE  minimum clk cycles ssel_ stays high between frames (>= 1)
//   Ports:
//     clk       in   system clock, rising edge
//     rst_n     in   asynchronous active-low reset
//     tx_data   in   8  byte to transmit
//     tx_valid  in   1  tx_data valid
//     tx_last   in   1  this byte ends the frame
//     tx_ready  out  1  byte accepted when tx_valid && tx_ready
//     rx_data   out  8  last captured byte
//     rx_valid  out  1  one-cycle strobe, rx_data updated
//     busy      out  1  frame in progress or inter-frame gap
//     sck       out  1  SPI clock, idles low
//     ssel_     out  1  chip select, active-low
//     mosi      out  1  controller data out
//     miso      in   1  peripheral data in (asynchronous)
// -----------------------------------------------------------------------------
module spi_controller
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned CS_IDLE = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       sck,
   output logic       ssel_,
   output logic       mosi,
   input  logic       miso
);

   localparam int unsigned HW = $clog2(CLK_DIV);
   localparam int unsigned GW = $clog2(CS_IDLE + 1);
   localparam logic [HW-1:0] C_HALF_LAST = HW'(CLK_DIV - 1);
   localparam logic [GW-1:0] C_GAP_LAST  = GW'(CS_IDLE - 1);

   if (CLK_DIV < SPI_MIN_CLK_DIV) begin : g_bad_clk_div
      $error("spi_controller: CLK_DIV must be at least %0d", SPI_MIN_CLK_DIV);
   end
   if (CS_IDLE < 1) begin : g_bad_cs_idle
      $error("spi_controller: CS_IDLE must be at least 1");
   end

   spi_ctrl_state_t r_state;
   spi_ctrl_state_t w_state_nxt;

   logic [HW-1:0] r_half_cnt;
   logic [GW-1:0] r_gap_cnt;
   logic [2:0]    r_bit_cnt;
   logic          r_sck;
   logic          r_ssel_n;
   logic          r_last;
   logic [7:0]    r_tx_shift;
   logic [6:0]    r_rx_shift;
   logic [7:0]    r_rx_data;
   logic          r_rx_valid;

   logic          w_miso_s;
   logic          w_half_end;
   logic          w_byte_done;
   logic          w_accept;
   logic          w_tx_ready;
   logic          w_busy;

   sync_2ff #(
      .WIDTH (1)
   ) u_miso_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (miso),
      .o_q   (w_miso_s)
   );

   assign w_half_end  = (r_half_cnt == C_HALF_LAST);
   // 8th falling edge: end of the high phase of bit 0
   assign w_byte_done = r_sck && w_half_end && (r_bit_cnt == 3'd7);
   assign w_accept    = tx_valid && w_tx_ready;

   // ---------------- FSM state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- FSM next state / decoded outputs ----------------
   always_comb begin
      w_state_nxt = r_state;
      w_tx_ready  = 1'b0;
      w_busy      = 1'b1;
      case (r_state)
         IDLE: begin
            w_tx_ready = 1'b1;
            w_busy     = 1'b0;
            if (tx_valid) w_state_nxt = SHIFT;
         end
         NEXT: begin
            w_tx_ready = 1'b1;
            if (tx_valid) w_state_nxt = SHIFT;
         end
         SHIFT: begin
            if (w_byte_done) w_state_nxt = r_last ? HOLD : NEXT;
         end
         HOLD: begin
            if (w_half_end) w_state_nxt = GAP;
         end
         GAP: begin
            if (r_gap_cnt == C_GAP_LAST) w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // ---------------- Datapath: counters, shifters, bus pins ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_half_cnt <= '0;
         r_gap_cnt  <= '0;
         r_bit_cnt  <= '0;
         r_sck      <= 1'b0;
         r_ssel_n   <= 1'b1;
         r_last     <= 1'b0;
         r_tx_shift <= '0;
         r_rx_shift <= '0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         // Chip select follows the next state so it is registered (glitch-free)
         // and drops on the same edge that presents bit 7 on mosi.
         r_ssel_n   <= (w_state_nxt == IDLE) || (w_state_nxt == GAP);
         r_gap_cnt  <= (r_state == GAP) ? r_gap_cnt + 1'b1 : '0;

         if (w_accept) begin
            r_tx_shift <= tx_data;
            r_last     <= tx_last;
            r_half_cnt <= '0;
            r_bit_cnt  <= '0;
            r_sck      <= 1'b0;
         end else if (r_state == SHIFT) begin
            r_half_cnt <= w_half_end ? '0 : r_half_cnt + 1'b1;
            if (w_half_end) begin
               r_sck <= ~r_sck;
               if (r_sck) begin
                  // Falling edge: miso taken at the last high-phase cycle,
                  // mosi advances to the next bit.
                  r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                  r_rx_shift <= {r_rx_shift[5:0], w_miso_s};
                  r_bit_cnt  <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     r_rx_data  <= {r_rx_shift, w_miso_s};
                     r_rx_valid <= 1'b1;
                  end
               end
            end
         end else if (r_state == HOLD) begin
            r_half_cnt <= w_half_end ? '0 : r_half_cnt + 1'b1;
         end
      end
   end

   assign tx_ready = w_tx_ready;
   assign busy     = w_busy;
   assign sck      = r_sck;
   assign ssel_    = r_ssel_n;
   assign mosi     = r_tx_shift[7];
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_controller
//   Self-checking bench for spi_controller (CLK_DIV=4, CS_IDLE=8).
//   Cycle numbers: cyc counts rising clk edges; all sampling is on the falling
//   edge. An accept "at cycle t" is the falling-edge sample where
//   tx_valid && tx_ready is seen; its effects are visible at t+1.
// -----------------------------------------------------------------------------
module tb_spi_controller;

   localparam int unsigned CLK_DIV  = 4;
   localparam int unsigned CS_IDLE  = 8;
   localparam int          BYTE_CYC = 16 * CLK_DIV + 1;
   localparam int          BOUND    = 2000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       sck;
   logic       ssel_;
   logic       mosi;
   logic       miso;

   spi_controller #(
      .CLK_DIV (CLK_DIV),
      .CS_IDLE (CS_IDLE)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_last  (tx_last),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy),
      .sck      (sck),
      .ssel_    (ssel_),
      .mosi     (mosi),
      .miso     (miso)
   );

   always #5 clk = ~clk;

   // Peripheral model: presents p_cur MSB first, advances after each sck fall.
   logic       loop_mode;
   logic [7:0] p_cur;
   int         p_cnt;
   logic       periph_bit;
   assign periph_bit = (p_cnt < 8) ? p_cur[3'(7 - p_cnt)] : 1'b0;
   assign miso       = loop_mode ? mosi : periph_bit;

   int         checks;
   int         failures;
   int         cyc;
   logic [7:0] exp_q[$];
   int         rx_cyc[$];
   int         inv_bad;
   int         ssel_rises;
   int         ssel_run;
   int         ssel_last_run;
   logic       ssel_d;

   typedef struct {
      logic [7:0] tx;
      logic       last;
      logic [7:0] resp;
      logic [7:0] exp;
      int         stall;
   } vec_t;

   vec_t tbl[5];
   int   tacc[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, expv, cyc);
      end
   endtask

   // Drive one byte, push its expected rx value, wait (bounded) for accept.
   task automatic send(input logic [7:0] d, input logic last, input logic [7:0] resp,
                       input logic [7:0] expv, output int t_acc);
      int w;
      tx_data  = d;
      tx_last  = last;
      tx_valid = 1'b1;
      exp_q.push_back(expv);
      w = 0;
      while (!tx_ready && w < BOUND) begin
         @(negedge clk);
         w++;
      end
      chk("accept_ready", tx_ready, 1);
      t_acc = cyc;
      @(negedge clk);
      p_cur    = resp;
      p_cnt    = 0;
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while (busy && w < BOUND) begin
         @(negedge clk);
         w++;
      end
      repeat (2) @(negedge clk);
      chk("idle_reached", busy, 0);
   endtask

   initial begin
      #(10 * 60000);
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t, t1, t2, n0, bus_bad, sck_rises, stall_bad, w;
      logic [7:0] seq, a5;
      logic prev_sck, e_sck, e_mosi, e_ssel;

      checks = 0; failures = 0; cyc = 0; inv_bad = 0;
      ssel_rises = 0; ssel_run = 0; ssel_last_run = 0; ssel_d = 1'b1;
      tx_data = '0; tx_valid = 1'b0; tx_last = 1'b0;
      loop_mode = 1'b1; p_cur = '0; p_cnt = 8;
      rst_n = 1'b0;

      tbl[0] = '{tx: 8'h01, last: 1'b0, resp: 8'h3C, exp: 8'h3C, stall: 0};
      tbl[1] = '{tx: 8'h02, last: 1'b0, resp: 8'hFF, exp: 8'hFF, stall: 0};
      tbl[2] = '{tx: 8'h03, last: 1'b1, resp: 8'h00, exp: 8'h00, stall: 0};
      tbl[3] = '{tx: 8'h10, last: 1'b0, resp: 8'hC3, exp: 8'hC3, stall: 0};
      tbl[4] = '{tx: 8'h20, last: 1'b1, resp: 8'h81, exp: 8'h81, stall: 50};

      fork
         forever begin
            @(posedge clk);
            cyc++;
         end
         forever begin
            @(negedge sck);
            if (!ssel_ && p_cnt < 8) p_cnt++;
         end
         forever begin
            @(negedge clk);
            if (rst_n) begin
               if (rx_valid) begin
                  rx_cyc.push_back(cyc);
                  if (exp_q.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL rx_unexpected actual=%0h expected=none (cyc %0d)", rx_data, cyc);
                  end else begin
                     chk("rx_data", rx_data, exp_q.pop_front());
                  end
               end
               if (tx_ready && sck) inv_bad++;
               if (tx_ready && ssel_ && busy) inv_bad++;
               if (sck && ssel_) inv_bad++;
            end
            if (ssel_) ssel_run++;
            else begin
               if (ssel_run > 0) ssel_last_run = ssel_run;
               ssel_run = 0;
            end
            if (ssel_ && !ssel_d) ssel_rises++;
            ssel_d = ssel_;
         end
      join_none

      // ---- reset values ----
      #12;
      chk("rst_sck", sck, 0);
      chk("rst_ssel", ssel_, 1);
      chk("rst_mosi", mosi, 0);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // ---- single byte, loopback ----
      loop_mode = 1'b1;
      rx_cyc.delete();
      a5 = 8'hA5;
      send(a5, 1'b1, 8'h00, a5, t);
      bus_bad = 0; sck_rises = 0; seq = '0; prev_sck = 1'b0;
      for (int k = 1; k <= 70; k++) begin
         e_sck  = (k <= 64) && ((((k - 1) / 4) % 2) == 1);
         e_mosi = (k <= 64) ? a5[3'(7 - (k - 1) / 8)] : 1'b0;
         e_ssel = (k >= 69);
         if (sck !== e_sck || mosi !== e_mosi || ssel_ !== e_ssel) bus_bad++;
         if (sck && !prev_sck) begin
            sck_rises++;
            seq = {seq[6:0], mosi};
         end
         prev_sck = sck;
         if (k < 70) @(negedge clk);
      end
      chk("lb_bus_profile_bad_cycles", bus_bad, 0);
      chk("lb_sck_pulses", sck_rises, 8);
      chk("lb_mosi_seq", seq, 8'hA5);
      wait_idle();
      chk("lb_rx_count", rx_cyc.size(), 1);
      if (rx_cyc.size() == 1) chk("lb_rx_latency", rx_cyc[0] - t, BYTE_CYC);
      chk("lb_rx_data_held", rx_data, 8'hA5);

      // ---- table: three-byte frame, then a frame with a stall in NEXT ----
      loop_mode = 1'b0;
      rx_cyc.delete();
      n0 = ssel_rises;
      for (int i = 0; i < 5; i++) begin
         if (tbl[i].stall > 0) begin
            w = 0;
            while (!tx_ready && w < BOUND) begin
               @(negedge clk);
               w++;
            end
            chk("stall_reach_next", tx_ready, 1);
            stall_bad = 0;
            for (int s = 0; s < tbl[i].stall; s++) begin
               if (ssel_ !== 1'b0 || sck !== 1'b0 || tx_ready !== 1'b1) stall_bad++;
               @(negedge clk);
            end
            chk("stall_bus_bad_cycles", stall_bad, 0);
         end
         send(tbl[i].tx, tbl[i].last, tbl[i].resp, tbl[i].exp, tacc[i]);
         if (tbl[i].stall > 0) begin
            chk("resume_ssel_low", ssel_, 0);
            repeat (CLK_DIV) @(negedge clk);
            chk("resume_first_sck_rise", sck, 1);
         end
      end
      wait_idle();
      chk("tbl_rx_count", rx_cyc.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < rx_cyc.size()) chk("tbl_rx_latency", rx_cyc[i] - tacc[i], BYTE_CYC);
      end
      chk("b2b_period_1", tacc[1] - tacc[0], BYTE_CYC);
      chk("b2b_period_2", tacc[2] - tacc[1], BYTE_CYC);
      chk("frames_ssel_rises", ssel_rises - n0, 2);

      // ---- inter-frame gap with tx_valid held high ----
      loop_mode = 1'b1;
      send(8'h66, 1'b1, 8'h00, 8'h66, t1);
      send(8'h99, 1'b1, 8'h00, 8'h99, t2);
      @(negedge clk);
      chk("gap_accept_spacing", t2 - t1, BYTE_CYC + CLK_DIV + CS_IDLE);
      chk("gap_ssel_high_min", ssel_last_run >= CS_IDLE, 1);
      wait_idle();

      // ---- reset during bit 3 ----
      n0 = rx_cyc.size();
      send(8'h5A, 1'b1, 8'h00, 8'h5A, t);
      repeat (26) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_ssel", ssel_, 1);
      chk("abort_sck", sck, 0);
      chk("abort_mosi", mosi, 0);
      chk("abort_busy", busy, 0);
      chk("abort_rx_valid", rx_valid, 0);
      chk("abort_pending_expect", exp_q.size(), 1);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (80) @(negedge clk);
      chk("abort_no_rx", rx_cyc.size(), n0);
      send(8'h5A, 1'b1, 8'h00, 8'h5A, t);
      wait_idle();
      chk("after_abort_rx_count", rx_cyc.size(), n0 + 1);
      chk("after_abort_rx_data", rx_data, 8'h5A);

      chk("invariants_bad_cycles", inv_bad, 0);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
